// File: rtl/cdma_ll_fetch.sv
// Linked-list descriptor fetcher: one cfg-side request becomes one or more AXI4 INCR reads (split at 4KB).
// Optional CDMA_LL_RESP_CHK_EN: a bad rresp/rid sets a sticky error and suppresses the rest of the descriptor.
module cdma_ll_fetch #(
  parameter int LL_WORDS = 6,
  parameter int AXI_IDW  = 4,
  parameter int LL_ID    = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ll_req_i,
  input  logic [31:0]        ll_addr_i,
  output logic               ll_ack_o,
  output logic               ll_dvld_o,
  output logic [31:0]        ll_rdata_o,
  output logic [2:0]         ll_dcnt_o,
  input  logic               dma_halt_i,
  output logic               ll_busy_o,
  output logic               ll_err_o,
  input  logic               ll_err_clr_i,
  output logic               arvalid_o,
  input  logic               arready_i,
  output logic [31:0]        araddr_o,
  output logic [7:0]         arlen_o,
  output logic [2:0]         arsize_o,
  output logic [1:0]         arburst_o,
  output logic [AXI_IDW-1:0] arid_o,
  input  logic               rvalid_i,
  output logic               rready_o,
  input  logic [31:0]        rdata_i,
  input  logic [1:0]         rresp_i,
  input  logic               rlast_i,
  input  logic [AXI_IDW-1:0] rid_i,
  output logic [1:0]         state_o
);

  // Handshakes: AR fires on arvalid_o & arready_i, R on rvalid_i & rready_o; arvalid_o and the AR
  // fields stay constant from assertion until that cycle. ll_ack_o/ll_dvld_o are single-cycle pulses.
  typedef enum logic [1:0] {S_IDLE, S_ACK, S_AR, S_RD} state_e;

  localparam logic [3:0]         LAST_PTR = 4'(LL_WORDS);
  localparam logic [AXI_IDW-1:0] ID_W     = AXI_IDW'(LL_ID);

  state_e      state_q, state_d;
  logic [29:0] base_q, base_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        dvld_q, dvld_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  dcnt_q, dcnt_d;
  logic        err_q, err_d;
  logic        bad_q, bad_d;
  logic        beat, bad_beat;

  logic [29:0] word_addr;
  logic [10:0] room;
  logic [3:0]  remain;
  logic [3:0]  len_words;

  // Words left before the 4KB page boundary caps the burst length.
  assign word_addr = base_q + 30'(ptr_q);
  assign room      = 11'd1024 - {1'b0, word_addr[9:0]};
  assign remain    = LAST_PTR - ptr_q;
  assign len_words = (room < {7'd0, remain}) ? room[3:0] : remain;

  assign beat = (state_q == S_RD) && rvalid_i;

`ifdef CDMA_LL_RESP_CHK_EN
  assign bad_beat = beat && ((rresp_i != 2'b00) || (rid_i != ID_W));
`else
  assign bad_beat = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    ptr_d   = ptr_q;
    dvld_d  = 1'b0;
    rdata_d = rdata_q;
    dcnt_d  = dcnt_q;
    err_d   = err_q;
    bad_d   = bad_q;
    if (ll_err_clr_i) err_d = 1'b0;
    if (bad_beat)     err_d = 1'b1;
    case (state_q)
      S_IDLE: if (ll_req_i && !dma_halt_i) state_d = S_ACK;
      S_ACK: begin
        base_d  = ll_addr_i[31:2];
        ptr_d   = 4'd0;
        bad_d   = 1'b0;
        state_d = S_AR;
      end
      S_AR: if (arready_i) state_d = S_RD;
      S_RD: begin
        if (rvalid_i) begin
          if (bad_beat) bad_d = 1'b1;
          // Beats past the descriptor length are consumed and dropped.
          if (ptr_q != LAST_PTR) begin
            ptr_d = ptr_q + 4'd1;
            if (!bad_beat && !bad_q) begin
              dvld_d  = 1'b1;
              rdata_d = rdata_i;
              dcnt_d  = ptr_q[2:0];
            end
          end
          if (rlast_i) state_d = (ptr_d == LAST_PTR) ? S_IDLE : S_AR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      ptr_q   <= '0;
      dvld_q  <= 1'b0;
      rdata_q <= '0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      ptr_q   <= ptr_d;
      dvld_q  <= dvld_d;
      rdata_q <= rdata_d;
      dcnt_q  <= dcnt_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
    end
  end

  assign ll_ack_o   = (state_q == S_ACK);
  assign ll_busy_o  = (state_q != S_IDLE);
  assign ll_dvld_o  = dvld_q;
  assign ll_rdata_o = rdata_q;
  assign ll_dcnt_o  = dcnt_q;
  assign ll_err_o   = err_q;
  assign arvalid_o  = (state_q == S_AR);
  assign araddr_o   = arvalid_o ? {word_addr, 2'b00} : 32'd0;
  assign arlen_o    = arvalid_o ? {4'd0, len_words - 4'd1} : 8'd0;
  assign arsize_o   = 3'b010;
  assign arburst_o  = 2'b01;
  assign arid_o     = ID_W;
  assign rready_o   = (state_q == S_RD);
  assign state_o    = state_q;

  logic unused_inputs;
  assign unused_inputs = ^{ll_addr_i[1:0], ll_err_clr_i, rresp_i, rid_i};

endmodule

// File: tb/tb_cdma_ll_fetch.sv
// Bench for cdma_ll_fetch: the bench plays the AXI slave and checks AR bursts and returned words
// against a descriptor/page-split model (define CDMA_LL_RESP_CHK_EN for the response-check build).
module tb_cdma_ll_fetch;
  localparam int LLW = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ll_req = 1'b0;
  logic [31:0] ll_addr = '0;
  logic        ll_ack, ll_dvld, ll_busy, ll_err;
  logic [31:0] ll_rdata;
  logic [2:0]  ll_dcnt;
  logic        dma_halt = 1'b0;
  logic        ll_err_clr = 1'b0;
  logic        arvalid, arready = 1'b0;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        rvalid = 1'b0, rready;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic [3:0]  rid = '0;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [34:0] exp_q[$];

  cdma_ll_fetch #(.LL_WORDS(LLW), .AXI_IDW(4), .LL_ID(0)) dut (
    .clk_i(clk), .rst_i(rst), .ll_req_i(ll_req), .ll_addr_i(ll_addr), .ll_ack_o(ll_ack),
    .ll_dvld_o(ll_dvld), .ll_rdata_o(ll_rdata), .ll_dcnt_o(ll_dcnt), .dma_halt_i(dma_halt),
    .ll_busy_o(ll_busy), .ll_err_o(ll_err), .ll_err_clr_i(ll_err_clr),
    .arvalid_o(arvalid), .arready_i(arready), .araddr_o(araddr), .arlen_o(arlen),
    .arsize_o(arsize), .arburst_o(arburst), .arid_o(arid),
    .rvalid_i(rvalid), .rready_o(rready), .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast),
    .rid_i(rid), .state_o(state)
  );

  always #5 clk = ~clk;

  // One descriptor fetch acting as AXI slave. bad_idx: word index answered with SLVERR (-1 none).
  // abort_after: reset is asserted once that many beats were delivered (-1 none).
  task automatic do_fetch(input logic [31:0] addr, input int ar_wait, input int bad_idx,
                          input int abort_after);
    logic [31:0] words[8];
    logic [31:0] base, ea;
    logic [34:0] got, e;
    int ptr, len, n_emit, waited, page_room;
    base = {addr[31:2], 2'b00};
    for (int i = 0; i < LLW; i++) words[i] = $urandom;
    n_emit = LLW;
`ifdef CDMA_LL_RESP_CHK_EN
    if (bad_idx >= 0) n_emit = bad_idx;
`endif
    if (abort_after >= 0 && abort_after < n_emit) n_emit = abort_after;
    exp_q.delete();
    for (int i = 0; i < n_emit; i++) exp_q.push_back({3'(i), words[i]});

    ll_addr = addr;
    ll_req  = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ll_ack !== 1'b1) begin
      n_fail++; $display("FAIL ack_latency got=%b exp=1", ll_ack);
    end
    ll_req = 1'b0;

    ptr = 0;
    while (ptr < LLW) begin
      ea = base + 32'(4 * ptr);
      len = LLW - ptr;
      page_room = (4096 - int'(ea[11:0])) / 4;
      if (page_room < len) len = page_room;
      waited = 0;
      while (arvalid !== 1'b1 && waited < 16) begin
        @(negedge clk);
        waited++;
      end
      n_checks++;
      if (arvalid !== 1'b1) begin
        n_fail++; $display("FAIL ar_timeout got=%b exp=1", arvalid);
        return;
      end
      n_checks++;
      if (araddr !== ea || arlen !== 8'(len - 1)) begin
        n_fail++; $display("FAIL ar_fields addr=%h len=%0d exp_addr=%h exp_len=%0d", araddr, arlen, ea, len - 1);
      end
      n_checks++;
      if (arsize !== 3'b010 || arburst !== 2'b01 || arid !== 4'd0 || rready !== 1'b0) begin
        n_fail++; $display("FAIL ar_const size=%b burst=%b id=%h rready=%b exp=010/01/0/0", arsize, arburst, arid, rready);
      end
      repeat (ar_wait) begin
        @(negedge clk);
        n_checks++;
        if (arvalid !== 1'b1 || araddr !== ea || arlen !== 8'(len - 1)) begin
          n_fail++; $display("FAIL ar_stable v=%b addr=%h len=%0d exp_addr=%h exp_len=%0d", arvalid, araddr, arlen, ea, len - 1);
        end
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      for (int b = 0; b < len; b++) begin
        n_checks++;
        if (rready !== 1'b1) begin
          n_fail++; $display("FAIL rready got=%b exp=1", rready);
        end
        rvalid = 1'b1;
        rdata  = words[ptr];
        rresp  = (ptr == bad_idx) ? 2'b10 : 2'b00;
        rid    = 4'd0;
        rlast  = (b == len - 1);
        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        n_checks++;
        if (ll_dvld !== (ptr < n_emit)) begin
          n_fail++; $display("FAIL dvld idx=%0d got=%b exp=%b", ptr, ll_dvld, ptr < n_emit);
        end
        if (ll_dvld === 1'b1) begin
          got = {ll_dcnt, ll_rdata};
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h0;
          n_checks++;
          if (got !== e) begin
            n_fail++; $display("FAIL word dcnt=%0d data=%h exp_dcnt=%0d exp_data=%h", got[34:32], got[31:0], e[34:32], e[31:0]);
          end
        end
        ptr++;
        if (ptr == abort_after) begin
          #2 rst = 1'b1;
          #1;
          n_checks++;
          if ({ll_ack, ll_dvld, ll_rdata, ll_dcnt, ll_busy, ll_err, arvalid, araddr, arlen, rready} !== '0) begin
            n_fail++; $display("FAIL reset_mid dvld=%b rdata=%h dcnt=%0d busy=%b rready=%b exp=0", ll_dvld, ll_rdata, ll_dcnt, ll_busy, rready);
          end
          @(negedge clk);
          rst = 1'b0;
          @(negedge clk);
          n_checks++;
          if (ll_dvld !== 1'b0 || ll_busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL after_reset dvld=%b busy=%b left=%0d exp=0", ll_dvld, ll_busy, exp_q.size());
          end
          return;
        end
      end
    end
    n_checks++;
    if (ll_busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL fetch_end busy=%b left=%0d exp=0/0", ll_busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({ll_ack, ll_dvld, ll_rdata, ll_dcnt, ll_busy, ll_err, arvalid, araddr, arlen, rready} !== '0) begin
      n_fail++; $display("FAIL reset_in busy=%b arvalid=%b rready=%b exp=0", ll_busy, arvalid, rready);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ll_ack, ll_dvld, ll_busy, ll_err, arvalid, rready} !== '0) begin
      n_fail++; $display("FAIL reset_out ack=%b busy=%b arvalid=%b exp=0", ll_ack, ll_busy, arvalid);
    end
  endtask

  task automatic test_basic();
    do_fetch(32'h1000_0040, 0, -1, -1);
    do_fetch(32'h0000_0FF8, 0, -1, -1);
  endtask

  task automatic test_ar_stall();
    do_fetch(32'h2000_0100, 10, -1, -1);
  endtask

  task automatic test_random();
    logic [31:0] page;
    logic [9:0]  offw;
    for (int k = 0; k < 8; k++) begin
      page = $urandom;
      offw = 10'(1024 - $urandom_range(1, 10));
      do_fetch({page[31:12], offw, 2'($urandom)}, $urandom_range(0, 3), -1, -1);
    end
  endtask

  task automatic test_halt();
    dma_halt = 1'b1;
    ll_req   = 1'b1;
    ll_addr  = 32'h3000_0000;
    repeat (20) begin
      @(negedge clk);
      n_checks++;
      if (ll_ack !== 1'b0 || arvalid !== 1'b0) begin
        n_fail++; $display("FAIL halt ack=%b arvalid=%b exp=0/0", ll_ack, arvalid);
      end
    end
    dma_halt = 1'b0;
    do_fetch(32'h3000_0000, 0, -1, -1);
  endtask

  task automatic test_resp_err();
    do_fetch(32'h4000_0200, 0, 2, -1);
`ifdef CDMA_LL_RESP_CHK_EN
    repeat (3) @(negedge clk);
    n_checks++;
    if (ll_err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky got=%b exp=1", ll_err);
    end
    ll_err_clr = 1'b1;
    @(negedge clk);
    ll_err_clr = 1'b0;
    n_checks++;
    if (ll_err !== 1'b0) begin
      n_fail++; $display("FAIL err_clear got=%b exp=0", ll_err);
    end
`else
    n_checks++;
    if (ll_err !== 1'b0) begin
      n_fail++; $display("FAIL err_tied got=%b exp=0", ll_err);
    end
`endif
    do_fetch(32'h4000_0300, 1, -1, -1);
  endtask

  task automatic test_reset_mid();
    do_fetch(32'h5000_0010, 0, -1, 3);
    do_fetch(32'h5000_0010, 0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ar_stall();
    test_halt();
    test_resp_err();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
